// File: rtl/coin_acceptor_encoder.sv
// Coin sensor front end: 2-flop synchroniser, debounce, pulse-width classifier
// and guard/drain sequencing. Emits a one-cycle coin code or reject strobe.
module coin_acceptor_encoder #(
  parameter int CNT_W   = 8,
  parameter int DEB_CYC = 4,
  parameter int A_MIN   = 8,
  parameter int A_MAX   = 15,
  parameter int B_MIN   = 16,
  parameter int B_MAX   = 31,
  parameter int C_MIN   = 32,
  parameter int C_MAX   = 63,
  parameter int GAP_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_sense,
  input  logic       en,
  output logic [1:0] d,
  output logic       reject,
  output logic       busy
);

  localparam int DC_W = $clog2(DEB_CYC + 1);
  localparam int GC_W = $clog2(GAP_CYC + 4);

  localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DEB_CYC - 1);
  localparam logic [GC_W-1:0]  GAP_LAST = GC_W'(GAP_CYC - 1);
  localparam logic [GC_W-1:0]  ARM_FILL = GC_W'(2);
  localparam logic [CNT_W-1:0] W_MAX    = '1;
  localparam logic [CNT_W-1:0] A_LO     = CNT_W'(A_MIN);
  localparam logic [CNT_W-1:0] A_HI     = CNT_W'(A_MAX);
  localparam logic [CNT_W-1:0] B_LO     = CNT_W'(B_MIN);
  localparam logic [CNT_W-1:0] B_HI     = CNT_W'(B_MAX);
  localparam logic [CNT_W-1:0] C_LO     = CNT_W'(C_MIN);
  localparam logic [CNT_W-1:0] C_HI     = CNT_W'(C_MAX);

  typedef enum logic [2:0] {
    ARM, IDLE, MEASURE, GAP, DRAIN
  } state_e;

  logic            s1_q, s_q;
  logic            db_q, db_d;
  logic [DC_W-1:0] dc_q, dc_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [GC_W-1:0]  gcnt_q, gcnt_d;
  logic             pend_q, pend_d;
  logic [1:0]       d_q, d_d;
  logic             rej_q, rej_d;
  logic [1:0]       code;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
      db_q <= 1'b0;
      dc_q <= '0;
    end else begin
      s1_q <= coin_sense;
      s_q  <= s1_q;
      db_q <= db_d;
      dc_q <= dc_d;
    end
  end

  always_comb begin
    db_d = db_q;
    dc_d = '0;
    if (s_q != db_q) begin
      if (dc_q == DC_LAST) db_d = s_q;
      else                 dc_d = dc_q + DC_W'(1);
    end
  end

  always_comb begin
    code = 2'b00;
    if      (wcnt_q >= A_LO && wcnt_q <= A_HI) code = 2'b01;
    else if (wcnt_q >= B_LO && wcnt_q <= B_HI) code = 2'b10;
    else if (wcnt_q >= C_LO && wcnt_q <= C_HI) code = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARM;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      pend_q  <= 1'b0;
      d_q     <= 2'b00;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      pend_q  <= pend_d;
      d_q     <= d_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    gcnt_d  = gcnt_q;
    pend_d  = pend_q;
    d_d     = 2'b00;
    rej_d   = 1'b0;
    unique case (state_q)
      // gcnt first lets the synchroniser refill, so stale reset zeros in s
      // cannot arm the FSM while a coin is still sitting in the sensor.
      ARM: begin
        if (gcnt_q != ARM_FILL) begin
          gcnt_d = gcnt_q + GC_W'(1);
        end else if (!db_q && !s_q) begin
          gcnt_d  = '0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (db_q) begin
          wcnt_d  = CNT_W'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (db_q) begin
          if (wcnt_q != W_MAX) wcnt_d = wcnt_q + CNT_W'(1);
        end else begin
          if (en && code != 2'b00) d_d = code;
          else                     rej_d = 1'b1;
          gcnt_d  = '0;
          pend_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        gcnt_d = gcnt_q + GC_W'(1);
        pend_d = pend_q | db_q;
        if (gcnt_q == GAP_LAST) begin
          gcnt_d  = '0;
          pend_d  = 1'b0;
          state_d = (db_q || pend_q) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (!db_q) begin
          rej_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = ARM;
    endcase
  end

  assign d      = d_q;
  assign reject = rej_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_coin_acceptor_encoder.sv
// Randomised + directed bench for coin_acceptor_encoder; a reference model
// predicts each pulse's outcome and cycle, a monitor matches DUT strobes.
module tb_coin_acceptor_encoder;

  localparam int DEB = 4;
  localparam int GAPC = 8;
  localparam int WSAT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_sense;
  logic       en;
  logic [1:0] d;
  logic       reject;
  logic       busy;

  coin_acceptor_encoder dut (
    .clk(clk), .rst(rst), .coin_sense(coin_sense), .en(en),
    .d(d), .reject(reject), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [1:0] code;
    logic       rej;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int last_fall = -1000;
  int prev_low = 0;

  // Outcome from the coin rules: width bands, saturation, en at the edge.
  function automatic exp_t classify(int w, bit e, int at);
    exp_t r;
    int ws;
    ws = (w > WSAT) ? WSAT : w;
    r.at = at; r.code = 2'b00; r.rej = 1'b0;
    if (!e)                      r.rej  = 1'b1;
    else if (ws >= 8  && ws <= 15) r.code = 2'b01;
    else if (ws >= 16 && ws <= 31) r.code = 2'b10;
    else if (ws >= 32 && ws <= 63) r.code = 2'b11;
    else                         r.rej  = 1'b1;
    return r;
  endfunction

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  // Called #1 after a posedge; leaves #1 after a posedge.
  task automatic pulse(int w, int low, bit en_edge, bit mid_en);
    int r, f;
    exp_t e;
    if (prev_low >= 20) chk("busy_idle", busy, 0);
    coin_sense = 1'b1;
    r = cyc + 1;
    for (int i = 0; i < w; i++) begin
      if (i == 3 && w > 5) en = mid_en;
      @(posedge clk); #1;
    end
    coin_sense = 1'b0;
    en = en_edge;
    f = cyc + 1;
    if (w >= DEB) begin
      if (r - last_fall >= 1 && r - last_fall <= GAPC) begin
        e.at = f + 6; e.code = 2'b00; e.rej = 1'b1;
      end else begin
        e = classify(w, en_edge, f + 6);
        last_fall = f;
      end
      q.push_back(e);
    end
    prev_low = low;
    repeat (low) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at < cyc) begin
      checks++; errors++;
      $display("FAIL missed_strobe: got none want code %0d rej %0d at cyc %0d",
               q[0].code, q[0].rej, q[0].at);
      void'(q.pop_front());
    end
    if (d != 2'b00 || reject) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got d %0d rej %0d at cyc %0d want none",
                 d, reject, cyc);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.at != cyc || mon_e.code != d || mon_e.rej != reject) begin
          errors++;
          $display("FAIL strobe: got d %0d rej %0d cyc %0d want d %0d rej %0d cyc %0d",
                   d, reject, cyc, mon_e.code, mon_e.rej, mon_e.at);
        end
      end
    end
  end

  initial begin
    int w, low;
    bit force_long;
    int wtab[11] = '{5, 7, 8, 15, 16, 31, 32, 63, 64, 100, 300};

    rst = 1'b0; coin_sense = 1'b0; en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d", d, 0);
    chk("rst_reject", reject, 0);
    chk("rst_busy", busy, 1);
    rst = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    prev_low = 20;

    // basic codes
    pulse(10, 25, 1, 1);
    pulse(20, 25, 1, 1);
    pulse(40, 25, 1, 1);
    // rejects, saturation, glitch
    pulse(5, 25, 1, 1);
    pulse(70, 25, 1, 1);
    pulse(300, 25, 1, 1);
    pulse(2, 25, 1, 1);
    // rise inside guard, and the guard boundary
    pulse(10, 5, 1, 1);
    pulse(20, 25, 1, 1);
    pulse(12, 8, 1, 1);
    pulse(20, 25, 1, 1);
    pulse(12, 9, 1, 1);
    pulse(20, 25, 1, 1);
    // en sampled only at the classify edge
    pulse(20, 25, 0, 1);
    pulse(20, 25, 1, 0);

    // reset mid-pulse: nothing reported for that pulse
    coin_sense = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 1);
    chk("midrst_d", d, 0);
    rst = 1'b1;
    last_fall = -1000;
    repeat (25) begin @(posedge clk); #1; end
    coin_sense = 1'b0;
    repeat (25) begin @(posedge clk); #1; end
    prev_low = 25;
    pulse(10, 25, 1, 1);

    // sense held high across reset release
    coin_sense = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    last_fall = -1000;
    repeat (30) begin @(posedge clk); #1; end
    chk("held_busy", busy, 1);
    coin_sense = 1'b0;
    repeat (25) begin @(posedge clk); #1; end
    prev_low = 25;
    pulse(20, 25, 1, 1);

    // randomised stream
    force_long = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (force_long) w = $urandom_range(12, 70);
      else begin
        int k;
        k = $urandom_range(0, 11);
        w = (k == 11) ? $urandom_range(5, 70) : wtab[k];
      end
      if ($urandom_range(0, 3) == 0) begin
        low = $urandom_range(4, 12); force_long = 1'b1;
      end else begin
        low = $urandom_range(20, 30); force_long = 1'b0;
      end
      pulse(w, low, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    repeat (30) begin @(posedge clk); #1; end
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
